module_serial_adder: RTL

// - Bit-serial adder stage around module_full_adder: latches two WIDTH-bit operands and a carry-in.
// - Feeds the full adder one bit pair per clock, LSB first, with the carry held in a flip-flop.
// - Shifts each sum bit into a result register; presents the registered sum/carry with a done pulse.
// - Sits between the operand source (switch/register bank) and the result display/consumer.
//

---
 rtl/module_serial_adder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/module_serial_adder.sv
// Bit-serial adder: latches two WIDTH-bit operands plus carry-in, adds them
// one bit pair per clock (LSB first) through a single full adder, and presents
// the registered sum/carry-out with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf_o.

module module_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // One-bit full adder.
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

module module_serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   logic             fa_s;
   logic             fa_cout;

   logic             last_bit;
   logic             load_en;
   logic             shift_en;
   logic             busy_d;
   logic             done_d;

   module_full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: SHIFT always runs exactly WIDTH cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i)  state_d = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Output/control decode; busy/done are precomputed so they can be registered.
   always_comb begin
      load_en  = 1'b0;
      shift_en = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE:  load_en  = start_i;
         ST_SHIFT: shift_en = 1'b1;
         default:  ;
      endcase
      busy_d = (state_d == ST_SHIFT) || (state_d == ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   // Registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         busy_o <= busy_d;
         done_o <= done_d;
      end
   end

   // Operand shift registers, carry flop and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (load_en) begin
         a_sh    <= a_i;
         b_sh    <= b_i;
         res_sh  <= '0;
         carry_q <= cin_i;
         cnt_q   <= '0;
      end else if (shift_en) begin
         a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
         res_sh  <= {fa_s, res_sh[WIDTH-1:1]};
         carry_q <= fa_cout;
         cnt_q   <= last_bit ? '0 : cnt_q + CW'(1);
      end
   end

   // Result registers, updated only on the final SHIFT edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_o  <= '0;
         cout_o <= 1'b0;
      end else if (shift_en && last_bit) begin
         sum_o  <= {fa_s, res_sh[WIDTH-1:1]};
         cout_o <= fa_cout;
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_o <= 1'b0;
      end else if (shift_en && last_bit) begin
         ovf_o <= carry_q ^ fa_cout;
      end
   end
`endif

endmodule
